// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encoding, default opcodes and DR-select helper.
package jtag_pkg;

    typedef enum logic [3:0] {
        TLR      = 4'd0,
        RTI      = 4'd1,
        SEL_IR   = 4'd2,
        CAP_IR   = 4'd3,
        SHIFT_IR = 4'd4,
        EXIT1_IR = 4'd5,
        PAUSE_IR = 4'd6,
        EXIT2_IR = 4'd7,
        UPD_IR   = 4'd8,
        SEL_DR   = 4'd9,
        CAP_DR   = 4'd10,
        SHIFT_DR = 4'd11,
        EXIT1_DR = 4'd12,
        PAUSE_DR = 4'd13,
        EXIT2_DR = 4'd14,
        UPD_DR   = 4'd15
    } tap_state_t;

    localparam int unsigned DEF_OP_EXTEST = 0;
    localparam int unsigned DEF_OP_SAMPLE = 1;
    localparam int unsigned DEF_OP_IDCODE = 2;

    // Anything that is not a known DR-owning opcode (including all-ones) routes to BYPASS.
    function automatic logic is_bypass(input int unsigned op,
                                       input int unsigned op_extest,
                                       input int unsigned op_sample,
                                       input int unsigned op_idcode);
        return !((op == op_extest) || (op == op_sample) || (op == op_idcode));
    endfunction

endpackage

// File: rtl/jtag_bsr.sv
// Boundary-scan register: capture/shift chain plus a separate update stage for the pads.
module jtag_bsr
    import jtag_pkg::*;
#(
    parameter int unsigned BSR_LEN = 8
) (
    input  logic               tclk,
    input  logic               trst,
    input  logic               capture_en,
    input  logic               shift_en,
    input  logic               update_en,
    input  logic               clear,
    input  logic               tdi,
    input  logic [BSR_LEN-1:0] pin_in,
    output logic               serial_out,
    output logic [BSR_LEN-1:0] update_q
);

    logic [BSR_LEN-1:0] shift_q;

    // Capture the pads or shift right with tdi entering at the MSB (shift form also works for a 1-cell chain).
    always_ff @(posedge tclk or posedge trst) begin
        if (trst) begin
            shift_q <= '0;
        end else if (capture_en) begin
            shift_q <= pin_in;
        end else if (shift_en) begin
            shift_q <= (shift_q >> 1) | (BSR_LEN'(tdi) << (BSR_LEN - 1));
        end
    end

    // Update stage only changes on an explicit update; Test-Logic-Reset wipes it.
    always_ff @(posedge tclk or posedge trst) begin
        if (trst) begin
            update_q <= '0;
        end else if (clear) begin
            update_q <= '0;
        end else if (update_en) begin
            update_q <= shift_q;
        end
    end

    assign serial_out = shift_q[0];

endmodule

// File: rtl/jtag_tap_bscan.sv
// TAP controller with IR, IDCODE, BYPASS and boundary-scan register driving the pad ring.
module jtag_tap_bscan
    import jtag_pkg::*;
#(
    parameter int unsigned IR_WIDTH     = 4,
    parameter int unsigned BSR_LEN      = 8,
    parameter logic [31:0] IDCODE_VALUE = 32'h1234_5679,
    parameter int unsigned OP_EXTEST    = DEF_OP_EXTEST,
    parameter int unsigned OP_SAMPLE    = DEF_OP_SAMPLE,
    parameter int unsigned OP_IDCODE    = DEF_OP_IDCODE
) (
    input  logic                tclk,
    input  logic                trst,
    input  logic                tms,
    input  logic                tdi,
    output logic                tdo,
    output logic                tdo_en,
    input  logic [BSR_LEN-1:0]  pin_in,
    input  logic [BSR_LEN-1:0]  core_out,
    output logic [BSR_LEN-1:0]  pin_out,
    output logic [3:0]          tap_state,
    output logic [IR_WIDTH-1:0] ir_active
);

    tap_state_t          state, next_state;
    logic [IR_WIDTH-1:0] ir_shift;
    logic [31:0]         id_shift;
    logic                bypass_q;
    logic                sel_bsr, sel_id, sel_byp;
    logic                bsr_serial, dr_lsb;
    logic [BSR_LEN-1:0]  bsr_update;

    // TAP state register.
    always_ff @(posedge tclk or posedge trst) begin
        if (trst) state <= TLR;
        else      state <= next_state;
    end

    // Standard 1149.1 transition graph; any unexpected encoding falls back to reset.
    always_comb begin
        next_state = state;
        case (state)
            TLR:      next_state = tms ? TLR      : RTI;
            RTI:      next_state = tms ? SEL_DR   : RTI;
            SEL_DR:   next_state = tms ? SEL_IR   : CAP_DR;
            SEL_IR:   next_state = tms ? TLR      : CAP_IR;
            CAP_IR:   next_state = tms ? EXIT1_IR : SHIFT_IR;
            SHIFT_IR: next_state = tms ? EXIT1_IR : SHIFT_IR;
            EXIT1_IR: next_state = tms ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: next_state = tms ? EXIT2_IR : PAUSE_IR;
            EXIT2_IR: next_state = tms ? UPD_IR   : SHIFT_IR;
            UPD_IR:   next_state = tms ? SEL_DR   : RTI;
            CAP_DR:   next_state = tms ? EXIT1_DR : SHIFT_DR;
            SHIFT_DR: next_state = tms ? EXIT1_DR : SHIFT_DR;
            EXIT1_DR: next_state = tms ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: next_state = tms ? EXIT2_DR : PAUSE_DR;
            EXIT2_DR: next_state = tms ? UPD_DR   : SHIFT_DR;
            UPD_DR:   next_state = tms ? SEL_DR   : RTI;
            default:  next_state = TLR;
        endcase
    end

    assign tap_state = state;

    assign sel_bsr = (ir_active == IR_WIDTH'(OP_EXTEST)) || (ir_active == IR_WIDTH'(OP_SAMPLE));
    assign sel_id  = (ir_active == IR_WIDTH'(OP_IDCODE));
    assign sel_byp = is_bypass(32'(ir_active), OP_EXTEST, OP_SAMPLE, OP_IDCODE);

    // Instruction register: capture the fixed 01 pattern, shift, then commit on Update-IR.
    always_ff @(posedge tclk or posedge trst) begin
        if (trst) begin
            ir_shift  <= '0;
            ir_active <= IR_WIDTH'(OP_IDCODE);
        end else begin
            case (state)
                TLR:      ir_active <= IR_WIDTH'(OP_IDCODE);
                CAP_IR:   ir_shift  <= IR_WIDTH'(2'b01);
                SHIFT_IR: ir_shift  <= {tdi, ir_shift[IR_WIDTH-1:1]};
                UPD_IR:   ir_active <= ir_shift;
                default:  ;
            endcase
        end
    end

    // IDCODE and BYPASS data registers; neither has an update stage.
    always_ff @(posedge tclk or posedge trst) begin
        if (trst) begin
            id_shift <= IDCODE_VALUE;
            bypass_q <= 1'b0;
        end else if (state == CAP_DR) begin
            if (sel_id)  id_shift <= IDCODE_VALUE;
            if (sel_byp) bypass_q <= 1'b0;
        end else if (state == SHIFT_DR) begin
            if (sel_id)  id_shift <= {tdi, id_shift[31:1]};
            if (sel_byp) bypass_q <= tdi;
        end
    end

    jtag_bsr #(
        .BSR_LEN (BSR_LEN)
    ) u_bsr (
        .tclk       (tclk),
        .trst       (trst),
        .capture_en ((state == CAP_DR)   && sel_bsr),
        .shift_en   ((state == SHIFT_DR) && sel_bsr),
        .update_en  ((state == UPD_DR)   && sel_bsr),
        .clear      (state == TLR),
        .tdi        (tdi),
        .pin_in     (pin_in),
        .serial_out (bsr_serial),
        .update_q   (bsr_update)
    );

    assign dr_lsb = sel_bsr ? bsr_serial : (sel_id ? id_shift[0] : bypass_q);

    // TDO presents the pre-shift LSB of whichever register is being shifted, one clock later.
    always_ff @(posedge tclk or posedge trst) begin
        if (trst) begin
            tdo    <= 1'b0;
            tdo_en <= 1'b0;
        end else if (state == SHIFT_IR) begin
            tdo    <= ir_shift[0];
            tdo_en <= 1'b1;
        end else if (state == SHIFT_DR) begin
            tdo    <= dr_lsb;
            tdo_en <= 1'b1;
        end else begin
            tdo    <= 1'b0;
            tdo_en <= 1'b0;
        end
    end

    assign pin_out = (ir_active == IR_WIDTH'(OP_EXTEST)) ? bsr_update : core_out;

endmodule

// File: tb/tb_jtag_tap_bscan.sv
// Self-checking bench for jtag_tap_bscan against a queue-based scan-chain model.
`timescale 1ns/1ps
module tb_jtag_tap_bscan;
    import jtag_pkg::*;

    localparam int IRW = 4;
    localparam int BL  = 8;
    localparam logic [31:0]    IDV    = 32'h1234_5679;
    localparam logic [IRW-1:0] OP_EXT = 4'd0;
    localparam logic [IRW-1:0] OP_SMP = 4'd1;
    localparam logic [IRW-1:0] OP_IDC = 4'd2;

    logic           tclk = 1'b0;
    logic           trst, tms, tdi, tdo, tdo_en;
    logic [BL-1:0]  pin_in, core_out, pin_out;
    logic [3:0]     tap_state;
    logic [IRW-1:0] ir_active;
    int errors = 0;
    int checks = 0;

    // Model: next-state tables, selected opcode, one FIFO per scan register (front = LSB).
    tap_state_t     nxt0 [16];
    tap_state_t     nxt1 [16];
    tap_state_t     m_state;
    logic [IRW-1:0] m_ir;
    logic [BL-1:0]  m_upd;
    logic           m_tdo, m_en;
    bit m_irq[$];
    bit m_bsq[$];
    bit m_idq[$];
    bit m_byq[$];

    jtag_tap_bscan #(
        .IR_WIDTH (IRW), .BSR_LEN (BL), .IDCODE_VALUE (IDV),
        .OP_EXTEST (0), .OP_SAMPLE (1), .OP_IDCODE (2)
    ) dut (
        .tclk (tclk), .trst (trst), .tms (tms), .tdi (tdi), .tdo (tdo), .tdo_en (tdo_en),
        .pin_in (pin_in), .core_out (core_out), .pin_out (pin_out),
        .tap_state (tap_state), .ir_active (ir_active)
    );

    always #5 tclk = ~tclk;

    function automatic void arc(input tap_state_t s, input tap_state_t a0, input tap_state_t a1);
        nxt0[int'(s)] = a0;
        nxt1[int'(s)] = a1;
    endfunction

    function automatic void init_arcs();
        arc(TLR, RTI, TLR);           arc(RTI, RTI, SEL_DR);
        arc(SEL_DR, CAP_DR, SEL_IR);  arc(SEL_IR, CAP_IR, TLR);
        arc(CAP_IR, SHIFT_IR, EXIT1_IR);   arc(CAP_DR, SHIFT_DR, EXIT1_DR);
        arc(SHIFT_IR, SHIFT_IR, EXIT1_IR); arc(SHIFT_DR, SHIFT_DR, EXIT1_DR);
        arc(EXIT1_IR, PAUSE_IR, UPD_IR);   arc(EXIT1_DR, PAUSE_DR, UPD_DR);
        arc(PAUSE_IR, PAUSE_IR, EXIT2_IR); arc(PAUSE_DR, PAUSE_DR, EXIT2_DR);
        arc(EXIT2_IR, SHIFT_IR, UPD_IR);   arc(EXIT2_DR, SHIFT_DR, UPD_DR);
        arc(UPD_IR, RTI, SEL_DR);          arc(UPD_DR, RTI, SEL_DR);
    endfunction

    function automatic int dr_kind(input logic [IRW-1:0] op);
        if (op == OP_EXT || op == OP_SMP) return 0;
        if (op == OP_IDC) return 1;
        return 2;
    endfunction

    function automatic void model_reset();
        logic [31:0] idv = IDV;
        m_state = TLR; m_ir = OP_IDC; m_upd = '0; m_tdo = 1'b0; m_en = 1'b0;
        m_irq.delete(); m_bsq.delete(); m_idq.delete(); m_byq.delete();
        for (int i = 0; i < IRW; i++) m_irq.push_back(1'b0);
        for (int i = 0; i < BL; i++)  m_bsq.push_back(1'b0);
        for (int i = 0; i < 32; i++)  m_idq.push_back(idv[i]);
        m_byq.push_back(1'b0);
    endfunction

    function automatic logic [BL-1:0] exp_pin();
        return (m_ir == OP_EXT) ? m_upd : core_out;
    endfunction

    // One tclk edge: drive at negedge, advance the model from the pre-edge state.
    task automatic clk_step(input logic t, input logic d);
        tap_state_t  s = m_state;
        int          k = dr_kind(m_ir);
        logic [31:0] idv = IDV;
        @(negedge tclk); tms = t; tdi = d;
        @(posedge tclk); #1;
        m_tdo = 1'b0; m_en = 1'b0;
        case (s)
            TLR:    begin m_ir = OP_IDC; m_upd = '0; end
            CAP_IR: begin
                m_irq.delete(); m_irq.push_back(1'b1);
                for (int i = 1; i < IRW; i++) m_irq.push_back(1'b0);
            end
            SHIFT_IR: begin m_tdo = m_irq.pop_front(); m_irq.push_back(d); m_en = 1'b1; end
            UPD_IR:   for (int i = 0; i < IRW; i++) m_ir[i] = m_irq[i];
            CAP_DR: begin
                if (k == 0) begin m_bsq.delete(); for (int i = 0; i < BL; i++) m_bsq.push_back(pin_in[i]); end
                else if (k == 1) begin m_idq.delete(); for (int i = 0; i < 32; i++) m_idq.push_back(idv[i]); end
                else begin m_byq.delete(); m_byq.push_back(1'b0); end
            end
            SHIFT_DR: begin
                if (k == 0)      begin m_tdo = m_bsq.pop_front(); m_bsq.push_back(d); end
                else if (k == 1) begin m_tdo = m_idq.pop_front(); m_idq.push_back(d); end
                else             begin m_tdo = m_byq.pop_front(); m_byq.push_back(d); end
                m_en = 1'b1;
            end
            UPD_DR: if (k == 0) for (int i = 0; i < BL; i++) m_upd[i] = m_bsq[i];
            default: ;
        endcase
        m_state = t ? nxt1[int'(s)] : nxt0[int'(s)];
    endtask

    task automatic apply_reset();
        @(negedge tclk); trst = 1'b1; tms = 1'b0; tdi = 1'b0;
        @(posedge tclk); @(posedge tclk); #1;
        model_reset();
        @(negedge tclk); trst = 1'b0;
    endtask

    task automatic goto_shift_dr();
        clk_step(1'b1, 1'b0); clk_step(1'b0, 1'b0); clk_step(1'b0, 1'b0);
    endtask

    task automatic goto_shift_ir();
        clk_step(1'b1, 1'b0); clk_step(1'b1, 1'b0); clk_step(1'b0, 1'b0); clk_step(1'b0, 1'b0);
    endtask

    task automatic finish_scan();
        clk_step(1'b1, 1'b0); clk_step(1'b0, 1'b0);
    endtask

    // Shift n bits (leaving on the last), collecting observed tdo and the model's expected tdo.
    task automatic scan(input int n, input logic [63:0] din, output logic [63:0] dout,
                        output logic [63:0] mexp, output int en_cnt);
        dout = '0; mexp = '0; en_cnt = 0;
        for (int i = 0; i < n; i++) begin
            clk_step(i == n - 1, din[i]);
            dout[i] = tdo; mexp[i] = m_tdo;
            if (tdo_en) en_cnt++;
        end
    endtask

    task automatic ir_load(input logic [IRW-1:0] op);
        logic [63:0] d, m; int e;
        goto_shift_ir(); scan(IRW, 64'(op), d, m, e); finish_scan();
    endtask

    task automatic test_reset();
        core_out = BL'($urandom); pin_in = BL'($urandom);
        apply_reset();
        checks++; if (tap_state !== 4'(TLR)) begin errors++; $display("[TB] FAIL reset_state: got %0d, expected %0d", tap_state, TLR); end
        checks++; if (ir_active !== OP_IDC) begin errors++; $display("[TB] FAIL reset_ir: got %h, expected %h", ir_active, OP_IDC); end
        checks++; if ({tdo, tdo_en} !== 2'b00) begin errors++; $display("[TB] FAIL reset_tdo: got %b, expected 00", {tdo, tdo_en}); end
        checks++; if (pin_out !== core_out) begin errors++; $display("[TB] FAIL reset_pin: got %h, expected %h", pin_out, core_out); end
        for (int i = 0; i < 5; i++) clk_step(1'b0, 1'b0);
        checks++; if (tap_state !== 4'(RTI)) begin errors++; $display("[TB] FAIL idle_state: got %0d, expected %0d", tap_state, RTI); end
        checks++; if (ir_active !== OP_IDC) begin errors++; $display("[TB] FAIL idle_ir: got %h, expected %h", ir_active, OP_IDC); end
    endtask

    task automatic test_idcode();
        logic [63:0] d, m; int e;
        goto_shift_dr();
        scan(32, {$urandom, $urandom}, d, m, e);
        checks++; if (d[31:0] !== IDV) begin errors++; $display("[TB] FAIL idcode: got %h, expected %h", d[31:0], IDV); end
        checks++; if (d[31:0] !== m[31:0]) begin errors++; $display("[TB] FAIL idcode_model: got %h, expected %h", d[31:0], m[31:0]); end
        checks++; if (e !== 32) begin errors++; $display("[TB] FAIL idcode_en: got %0d, expected 32", e); end
        clk_step(1'b1, 1'b0);
        checks++; if (tdo_en !== 1'b0) begin errors++; $display("[TB] FAIL idcode_en_off: got %b, expected 0", tdo_en); end
        clk_step(1'b0, 1'b0);
    endtask

    task automatic test_ir_bypass();
        logic [63:0] d, m, din; int e; logic [IRW-1:0] op;
        goto_shift_ir();
        scan(IRW, 64'hF, d, m, e);
        checks++; if (d[1:0] !== 2'b01) begin errors++; $display("[TB] FAIL ir_capture: got %b, expected 01", d[1:0]); end
        checks++; if (d[3:0] !== m[3:0]) begin errors++; $display("[TB] FAIL ir_capture_model: got %b, expected %b", d[3:0], m[3:0]); end
        finish_scan();
        checks++; if (ir_active !== 4'hF) begin errors++; $display("[TB] FAIL ir_update: got %h, expected F", ir_active); end
        goto_shift_dr();
        scan(4, 64'b1101, d, m, e);
        checks++; if (d[3:0] !== 4'b1010) begin errors++; $display("[TB] FAIL bypass_stream: got %b, expected 1010", d[3:0]); end
        finish_scan();
        op = IRW'($urandom_range(3, 14));
        ir_load(op);
        din = {$urandom, $urandom};
        goto_shift_dr();
        scan(10, din, d, m, e);
        checks++; if (d[9:0] !== {din[8:0], 1'b0}) begin errors++; $display("[TB] FAIL bypass_undef op=%h: got %h, expected %h", op, d[9:0], {din[8:0], 1'b0}); end
        finish_scan();
    endtask

    task automatic test_sample();
        logic [63:0] d, m; int e;
        core_out = 8'h00; pin_in = 8'hA5;
        ir_load(OP_SMP);
        checks++; if (ir_active !== OP_SMP) begin errors++; $display("[TB] FAIL sample_ir: got %h, expected %h", ir_active, OP_SMP); end
        goto_shift_dr();
        scan(BL, 64'h3C, d, m, e);
        checks++; if (d[7:0] !== 8'hA5) begin errors++; $display("[TB] FAIL sample_capture: got %h, expected A5", d[7:0]); end
        finish_scan();
        checks++; if (pin_out !== 8'h00) begin errors++; $display("[TB] FAIL sample_pin: got %h, expected 00", pin_out); end
    endtask

    task automatic test_extest();
        logic [63:0] d, m; int e;
        goto_shift_ir();
        scan(IRW, 64'(OP_EXT), d, m, e);
        clk_step(1'b1, 1'b0);
        checks++; if (pin_out !== core_out) begin errors++; $display("[TB] FAIL extest_pre: got %h, expected %h", pin_out, core_out); end
        clk_step(1'b0, 1'b0);
        checks++; if (pin_out !== 8'h3C) begin errors++; $display("[TB] FAIL extest_drive: got %h, expected 3C", pin_out); end
        core_out = BL'($urandom); #1;
        checks++; if (pin_out !== 8'h3C) begin errors++; $display("[TB] FAIL extest_hold: got %h, expected 3C", pin_out); end
        for (int i = 0; i < 5; i++) clk_step(1'b1, 1'b0);
        checks++; if (tap_state !== 4'(TLR)) begin errors++; $display("[TB] FAIL tms5_state: got %0d, expected %0d", tap_state, TLR); end
        checks++; if (ir_active !== OP_IDC) begin errors++; $display("[TB] FAIL tms5_ir: got %h, expected %h", ir_active, OP_IDC); end
        checks++; if (pin_out !== core_out) begin errors++; $display("[TB] FAIL tms5_pin: got %h, expected %h", pin_out, core_out); end
        clk_step(1'b0, 1'b0);
    endtask

    task automatic test_pause();
        logic [7:0] pv, din, dout;
        core_out = BL'($urandom); pin_in = BL'($urandom); pv = pin_in; din = 8'($urandom);
        ir_load(OP_SMP);
        goto_shift_dr();
        for (int i = 0; i < 3; i++) begin clk_step(i == 2, din[i]); dout[i] = tdo; end
        clk_step(1'b0, 1'b0);
        pin_in = ~pv;
        for (int i = 0; i < 3; i++) clk_step(1'b0, 1'($urandom));
        checks++; if (tap_state !== 4'(PAUSE_DR)) begin errors++; $display("[TB] FAIL pause_state: got %0d, expected %0d", tap_state, PAUSE_DR); end
        checks++; if (tdo_en !== 1'b0) begin errors++; $display("[TB] FAIL pause_en: got %b, expected 0", tdo_en); end
        clk_step(1'b1, 1'b0); clk_step(1'b0, 1'b0);
        for (int i = 3; i < 8; i++) begin clk_step(i == 7, din[i]); dout[i] = tdo; end
        checks++; if (dout !== pv) begin errors++; $display("[TB] FAIL pause_stream: got %h, expected %h", dout, pv); end
        finish_scan();
        ir_load(OP_EXT);
        checks++; if (pin_out !== din) begin errors++; $display("[TB] FAIL pause_update: got %h, expected %h", pin_out, din); end
    endtask

    task automatic test_mid_reset();
        goto_shift_dr();
        clk_step(1'b0, 1'b1); clk_step(1'b0, 1'b1);
        checks++; if (tdo_en !== 1'b1) begin errors++; $display("[TB] FAIL midrst_shifting: got %b, expected 1", tdo_en); end
        @(negedge tclk); trst = 1'b1; tms = 1'b0; #1;
        checks++; if ({tdo, tdo_en} !== 2'b00) begin errors++; $display("[TB] FAIL midrst_tdo: got %b, expected 00", {tdo, tdo_en}); end
        checks++; if (tap_state !== 4'(TLR)) begin errors++; $display("[TB] FAIL midrst_state: got %0d, expected %0d", tap_state, TLR); end
        checks++; if (pin_out !== core_out) begin errors++; $display("[TB] FAIL midrst_pin: got %h, expected %h", pin_out, core_out); end
        @(posedge tclk); @(posedge tclk); #1;
        checks++; if (tap_state !== 4'(TLR) || tdo_en !== 1'b0) begin errors++; $display("[TB] FAIL midrst_hold: got %0d/%b, expected %0d/0", tap_state, tdo_en, TLR); end
        model_reset();
        @(negedge tclk); trst = 1'b0;
        clk_step(1'b0, 1'b0);
        ir_load(OP_EXT);
        checks++; if (pin_out !== '0) begin errors++; $display("[TB] FAIL midrst_update: got %h, expected 00", pin_out); end
    endtask

    task automatic test_random_walk();
        logic t;
        for (int n = 0; n < 400; n++) begin
            pin_in = BL'($urandom);
            if (($urandom % 8) == 0) core_out = BL'($urandom);
            t = (($urandom % 3) == 0);
            clk_step(t, 1'($urandom));
            checks++; if (tap_state !== 4'(m_state)) begin errors++; $display("[TB] FAIL walk_state n=%0d: got %0d, expected %0d", n, tap_state, m_state); end
            checks++; if ({tdo, tdo_en} !== {m_tdo, m_en}) begin errors++; $display("[TB] FAIL walk_tdo n=%0d: got %b, expected %b", n, {tdo, tdo_en}, {m_tdo, m_en}); end
            checks++; if (ir_active !== m_ir) begin errors++; $display("[TB] FAIL walk_ir n=%0d: got %h, expected %h", n, ir_active, m_ir); end
            checks++; if (pin_out !== exp_pin()) begin errors++; $display("[TB] FAIL walk_pin n=%0d: got %h, expected %h", n, pin_out, exp_pin()); end
        end
    endtask

    initial begin
        trst = 1'b1; tms = 1'b1; tdi = 1'b0; pin_in = '0; core_out = '0;
        init_arcs();
        model_reset();
        $display("[TB] starting jtag_tap_bscan bench");
        test_reset();
        test_idcode();
        test_ir_bypass();
        test_sample();
        test_extest();
        test_pause();
        test_mid_reset();
        test_random_walk();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
